// File: rtl/mul_issue_queue_if.sv
// Issue bus between the multiply issue queue and the multiplier.
// master: queue drives issue_*; slave: unit drives fu_ready.
interface mul_issue_queue_if #(
  parameter int WORD_WIDTH  = 32,
  parameter int OP_WIDTH    = 8,
  parameter int PADDR_WIDTH = 5
);
  logic                   issue_en;
  logic [OP_WIDTH-1:0]    issue_op;
  logic [WORD_WIDTH-1:0]  issue_rs1_value;
  logic [WORD_WIDTH-1:0]  issue_rs2_value;
  logic [PADDR_WIDTH-1:0] issue_Pdst;
  logic                   fu_ready;

  modport master (
    output issue_en,
    output issue_op,
    output issue_rs1_value,
    output issue_rs2_value,
    output issue_Pdst,
    input  fu_ready
  );

  modport slave (
    input  issue_en,
    input  issue_op,
    input  issue_rs1_value,
    input  issue_rs2_value,
    input  issue_Pdst,
    output fu_ready
  );
endinterface

// File: rtl/mul_issue_queue.sv
// Age-ordered multiply issue queue with CDB wakeup and collapse.
// Ports: clk/rst_n, flush, dispatch_*, cdb_*, iss (issue bus), iq_full/iq_count.
module mul_issue_queue #(
  parameter int IQ_DEPTH    = 4,
  parameter int WORD_WIDTH  = 32,
  parameter int OP_WIDTH    = 8,
  parameter int PADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     dispatch_en,
  input  logic [OP_WIDTH-1:0]      dispatch_op,
  input  logic                     dispatch_rs1_ready,
  input  logic                     dispatch_rs2_ready,
  input  logic [WORD_WIDTH-1:0]    dispatch_rs1_value,
  input  logic [WORD_WIDTH-1:0]    dispatch_rs2_value,
  input  logic [PADDR_WIDTH-1:0]   dispatch_rs1_Paddr,
  input  logic [PADDR_WIDTH-1:0]   dispatch_rs2_Paddr,
  input  logic [PADDR_WIDTH-1:0]   dispatch_Pdst,
  input  logic                     cdb_valid,
  input  logic [PADDR_WIDTH-1:0]   cdb_Paddr,
  input  logic [WORD_WIDTH-1:0]    cdb_value,
  mul_issue_queue_if.master        iss,
  output logic                     iq_full,
  output logic [$clog2(IQ_DEPTH):0] iq_count
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;

  typedef struct packed {
    logic                   valid;
    logic [OP_WIDTH-1:0]    op;
    logic [PADDR_WIDTH-1:0] pdst;
    logic                   rs1_rdy;
    logic [WORD_WIDTH-1:0]  rs1_val;
    logic [PADDR_WIDTH-1:0] rs1_tag;
    logic                   rs2_rdy;
    logic [WORD_WIDTH-1:0]  rs2_val;
    logic [PADDR_WIDTH-1:0] rs2_tag;
  } entry_t;

  entry_t         q   [IQ_DEPTH];
  entry_t         nx  [IQ_DEPTH];
  entry_t         wk  [IQ_DEPTH+1];
  entry_t         ne;
  entry_t         cand;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nx;
  logic [CW-1:0]  sel;
  logic [CW-1:0]  wr;
  logic           found;
  logic           issue;
  logic           enq;

  assign iq_count = count;
  assign iq_full  = (count == CW'(IQ_DEPTH));

  // Oldest-first select: scan downward so the lowest ready index wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy) begin
        found = 1'b1;
        sel   = CW'(i);
        cand  = q[i];
      end
    end
  end

  assign issue = iss.fu_ready & found & ~flush;
  assign enq   = dispatch_en & ~iq_full;

  always_comb begin
    iss.issue_en        = issue;
    iss.issue_op        = issue ? cand.op      : '0;
    iss.issue_rs1_value = issue ? cand.rs1_val : '0;
    iss.issue_rs2_value = issue ? cand.rs2_val : '0;
    iss.issue_Pdst      = issue ? cand.pdst    : '0;
  end

  // Incoming entry, with same-cycle CDB bypass so no wakeup is lost.
  always_comb begin
    ne         = '0;
    ne.valid   = 1'b1;
    ne.op      = dispatch_op;
    ne.pdst    = dispatch_Pdst;
    ne.rs1_rdy = dispatch_rs1_ready;
    ne.rs1_val = dispatch_rs1_value;
    ne.rs1_tag = dispatch_rs1_Paddr;
    ne.rs2_rdy = dispatch_rs2_ready;
    ne.rs2_val = dispatch_rs2_value;
    ne.rs2_tag = dispatch_rs2_Paddr;
    if (cdb_valid && !dispatch_rs1_ready &&
        cdb_Paddr == dispatch_rs1_Paddr) begin
      ne.rs1_rdy = 1'b1;
      ne.rs1_val = cdb_value;
    end
    if (cdb_valid && !dispatch_rs2_ready &&
        cdb_Paddr == dispatch_rs2_Paddr) begin
      ne.rs2_rdy = 1'b1;
      ne.rs2_val = cdb_value;
    end
  end

  // Wakeup first, then collapse over the issued slot, then enqueue.
  // The extra top slot of wk is an empty entry shifted into the tail.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      wk[i] = q[i];
      if (q[i].valid && cdb_valid) begin
        if (!q[i].rs1_rdy && cdb_Paddr == q[i].rs1_tag) begin
          wk[i].rs1_rdy = 1'b1;
          wk[i].rs1_val = cdb_value;
        end
        if (!q[i].rs2_rdy && cdb_Paddr == q[i].rs2_tag) begin
          wk[i].rs2_rdy = 1'b1;
          wk[i].rs2_val = cdb_value;
        end
      end
    end
    wk[IQ_DEPTH] = '0;

    wr = count - CW'(issue);
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (issue && CW'(i) >= sel)
        nx[i] = wk[i+1];
      else
        nx[i] = wk[i];
      if (enq && CW'(i) == wr)
        nx[i] = ne;
    end

    count_nx = count + CW'(enq) - CW'(issue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < IQ_DEPTH; i++)
        q[i] <= '0;
    end else if (flush) begin
      count <= '0;
      for (int i = 0; i < IQ_DEPTH; i++)
        q[i] <= '0;
    end else begin
      count <= count_nx;
      for (int i = 0; i < IQ_DEPTH; i++)
        q[i] <= nx[i];
    end
  end

endmodule
